// File: rtl/ad9253_avg_serializer.sv
// ---------------------------------------------------------------------------
// ad9253_avg_serializer
//
// Box-car averages 2^LOG2_AVG consecutive valid samples on each of the four
// AD9253 channels. Each finished set of four averages is then sent out one
// word at a time on a valid/ready interface, and each word carries its
// channel number.
//
// Optional build macro: AVG_ROUND_EN
//   undefined : average = (acc + sample) >> LOG2_AVG, truncating
//   defined   : average = sat((acc + sample + 2^(LOG2_AVG-1)) >> LOG2_AVG),
//               round-half-up, saturated at 2^DATA_W-1
//
// Parameters
//   DATA_W    sample width per channel (unsigned, offset-binary)
//   LOG2_AVG  log2 of the number of samples per set (0 = pass-through)
//
// Ports
//   clk        block clock
//   Rst_n      asynchronous active-low reset
//   Data_VLD   sample strobe, Data_CH0..3 valid when high
//   Data_CH0-3 channel samples
//   out_ready  downstream accepts out_data this cycle
//   clr_ovr    clears the sticky overrun flag
//   out_valid  out_data holds a word
//   out_data   {ch_id[1:0], avg[DATA_W-1:0]}
//   out_last   high together with the channel-3 word
//   overrun    sticky: an averaged set was dropped because of back-pressure
// ---------------------------------------------------------------------------
module ad9253_avg_serializer #(
    parameter int DATA_W   = 14,
    parameter int LOG2_AVG = 2
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              Data_VLD,
    input  logic [DATA_W-1:0] Data_CH0,
    input  logic [DATA_W-1:0] Data_CH1,
    input  logic [DATA_W-1:0] Data_CH2,
    input  logic [DATA_W-1:0] Data_CH3,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic              out_valid,
    output logic [DATA_W+1:0] out_data,
    output logic              out_last,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'((1 << DATA_W) - 1);
`ifdef AVG_ROUND_EN
    localparam int               RND_SH   = (LOG2_AVG > 0) ? (LOG2_AVG - 1) : 0;
    localparam logic [SUM_W-1:0] RND_INC  = (LOG2_AVG > 0) ? (SUM_W'(1) << RND_SH) : '0;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Clamp a shifted sum to the largest sample value.
    function automatic logic [DATA_W-1:0] sat_avg(input logic [SUM_W-1:0] q);
        if (q > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end
        return q[DATA_W-1:0];
    endfunction

    // Average of a finished set: the accumulator plus the final sample of the
    // set, divided by the set size. The sum is one bit wider than the
    // accumulator so that the rounding increment cannot wrap.
    function automatic logic [DATA_W-1:0] calc_avg(input logic [ACC_W-1:0]  acc,
                                                   input logic [DATA_W-1:0] smp);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(smp);
`ifdef AVG_ROUND_EN
        sum = sum + RND_INC;
`endif
        return sat_avg(sum >> LOG2_AVG);
    endfunction

    logic [3:0][DATA_W-1:0] smp;
    logic [3:0][DATA_W-1:0] avg;

    logic [3:0][ACC_W-1:0]  acc_q,  acc_d;
    logic [3:0][DATA_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;
    logic [0:0]             state_q, state_d;
    logic [1:0]             idx_q,  idx_d;
    logic                   ovr_q,  ovr_d;

    logic complete;
    logic word_acc;
    logic last_acc;
    logic drop;

    always_comb begin
        smp[0] = Data_CH0;
        smp[1] = Data_CH1;
        smp[2] = Data_CH2;
        smp[3] = Data_CH3;
    end

    always_comb begin
        acc_d   = acc_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        drop    = 1'b0;
        avg     = '0;

        complete = Data_VLD && ((LOG2_AVG == 0) || (cnt_q == CNT_LAST));
        word_acc = (state_q == SEND) && out_ready;
        last_acc = word_acc && (idx_q == 2'd3);

        // Accumulate; the final sample of a set goes straight into the
        // average and the accumulators restart from zero.
        if (Data_VLD) begin
            if (LOG2_AVG > 0) begin
                cnt_d = cnt_q + 1'b1;
            end
            for (int ch = 0; ch < 4; ch++) begin
                avg[ch] = calc_avg(acc_q[ch], smp[ch]);
                if (complete) begin
                    acc_d[ch] = '0;
                end else begin
                    acc_d[ch] = acc_q[ch] + ACC_W'(smp[ch]);
                end
            end
        end

        if (word_acc) begin
            idx_d = idx_q + 2'd1;
            if (last_acc) begin
                state_d = IDLE;
            end
        end

        // A new set may be loaded while idle or in the very cycle the last
        // word of the previous set leaves; at any other time it is lost.
        if (complete) begin
            if ((state_q == IDLE) || last_acc) begin
                hold_d  = avg;
                idx_d   = 2'd0;
                state_d = SEND;
            end else begin
                drop = 1'b1;
            end
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = out_valid ? {idx_q, hold_q[idx_q]} : '0;
        out_last  = out_valid && (idx_q == 2'd3);
        overrun   = ovr_q;
    end

endmodule
